// File: rtl/note_scheduler.sv
// note_scheduler: spawns chart notes into a pool of dropper slots and keeps the score state.
// Build macro NOTE_SKIP_EN: a chart entry that stays blocked for lack of a free slot is
// dropped after eight stalled cycles and counted as a miss. Without it the chart just waits.
module note_scheduler #(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned CHART_DEPTH = 32,
    parameter int unsigned TICK_W      = 12,
    parameter int unsigned HIT_POINTS  = 10,
    localparam int unsigned AW         = $clog2(CHART_DEPTH)
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode,
    input  logic [7:0]           keycode_second,
    output logic [AW-1:0]        chart_addr,
    input  logic                 chart_valid,
    input  logic [TICK_W-1:0]    chart_tick,
    input  logic [1:0]           chart_lane,
    output logic [NUM_SLOTS-1:0] slot_spawn,
    output logic [1:0]           slot_lane,
    output logic                 slot_clear,
    input  logic [NUM_SLOTS-1:0] slot_done,
    input  logic [NUM_SLOTS-1:0] slot_hit,
    output logic [TICK_W-1:0]    song_tick,
    output logic [15:0]          score,
    output logic [7:0]           combo,
    output logic [7:0]           miss_count,
    output logic                 playing,
    output logic                 finished
);
    typedef enum logic [1:0] {StIdle, StPlay, StDrain, StEnd} state_e;

    localparam logic [7:0] KeyStart = 8'h2C;
    localparam logic [7:0] KeyAbort = 8'h29;
    localparam logic [7:0] KeyExit  = 8'h01;

    state_e               state;
    logic [NUM_SLOTS-1:0] reserved, pending, hit_latch;
    logic [NUM_SLOTS-1:0] free_oh, svc_oh, capture;
    logic                 key_start, key_abort, key_exit, active, abort;
    logic                 entry_due, stalled, do_spawn, do_skip;
    logic                 free_found, svc_found, svc_hit, last_entry;
    logic [16:0]          score_sum;
    logic [8:0]           miss_sum;
    logic [1:0]           miss_inc;
    logic [15:0]          score_nx;
    logic [7:0]           combo_nx, miss_nx;
    logic [TICK_W-1:0]    tick_nx;

    assign key_start = (keycode == KeyStart) || (keycode_second == KeyStart);
    assign key_abort = (keycode == KeyAbort) || (keycode_second == KeyAbort);
    assign key_exit  = (keycode == KeyExit)  || (keycode_second == KeyExit);

    assign active     = (state == StPlay) || (state == StDrain);
    assign abort      = active && key_abort;
    // An abort in the same cycle suppresses any spawn or stall bookkeeping.
    assign entry_due  = (state == StPlay) && !key_abort && chart_valid && (chart_tick <= song_tick);
    assign do_spawn   = entry_due && free_found;
    assign stalled    = entry_due && !free_found;
    assign capture    = slot_done & reserved;
    assign svc_hit    = |(svc_oh & hit_latch);
    assign last_entry = (chart_addr == AW'(CHART_DEPTH - 1));
    assign tick_nx    = (song_tick == '1) ? song_tick : song_tick + TICK_W'(1);

    assign slot_spawn = do_spawn ? free_oh : '0;
    assign slot_lane  = do_spawn ? chart_lane : 2'd0;
    assign slot_clear = abort;
    assign playing    = active;
    assign finished   = (state == StEnd);

    // Pick the lowest-index free slot for spawning and the lowest-index pending slot to service
    always_comb begin
        free_found = 1'b0;
        free_oh    = '0;
        svc_found  = 1'b0;
        svc_oh     = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (!reserved[i] && !free_found) begin
                free_found = 1'b1;
                free_oh[i] = 1'b1;
            end
            if (pending[i] && !svc_found) begin
                svc_found = 1'b1;
                svc_oh[i] = 1'b1;
            end
        end
    end

`ifdef NOTE_SKIP_EN
    logic [2:0] stall_cnt;

    assign do_skip = stalled && (stall_cnt == 3'd7);

    // Stall counter: counts stalled PLAY cycles, cleared by a spawn, a skip or a new song
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= '0;
        end else if ((state == StIdle) && key_start) begin
            stall_cnt <= '0;
        end else if (do_spawn || do_skip) begin
            stall_cnt <= '0;
        end else if (stalled) begin
            stall_cnt <= stall_cnt + 3'd1;
        end
    end
`else
    assign do_skip = 1'b0;
`endif

    // Saturating score/combo/miss update for one serviced slot plus an optional skip
    always_comb begin
        score_nx  = score;
        combo_nx  = combo;
        miss_inc  = 2'd0;
        score_sum = {1'b0, score} + 17'(HIT_POINTS);
        if (svc_found) begin
            if (svc_hit) begin
                score_nx = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                combo_nx = (combo == 8'hFF) ? combo : combo + 8'd1;
            end else begin
                combo_nx = '0;
                miss_inc = 2'd1;
            end
        end
        if (do_skip) begin
            combo_nx = '0;
            miss_inc = miss_inc + 2'd1;
        end
        miss_sum = {1'b0, miss_count} + {7'd0, miss_inc};
        miss_nx  = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end

    // Game FSM together with chart pointer, slot masks and score registers
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= StIdle;
            chart_addr <= '0;
            reserved   <= '0;
            pending    <= '0;
            hit_latch  <= '0;
            song_tick  <= '0;
            score      <= '0;
            combo      <= '0;
            miss_count <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (key_start) begin
                        state      <= StPlay;
                        chart_addr <= '0;
                        reserved   <= '0;
                        pending    <= '0;
                        hit_latch  <= '0;
                        song_tick  <= '0;
                        score      <= '0;
                        combo      <= '0;
                        miss_count <= '0;
                    end
                end
                StPlay, StDrain: begin
                    if (key_abort) begin
                        state    <= StIdle;
                        reserved <= '0;
                        pending  <= '0;
                    end else begin
                        song_tick  <= tick_nx;
                        score      <= score_nx;
                        combo      <= combo_nx;
                        miss_count <= miss_nx;
                        // A slot serviced this cycle is freed; it can respawn next cycle
                        reserved   <= (reserved | slot_spawn) & ~svc_oh;
                        pending    <= (pending | capture) & ~svc_oh;
                        hit_latch  <= (hit_latch & ~capture) | (slot_hit & capture);
                        if (state == StPlay) begin
                            if (do_spawn || do_skip) begin
                                chart_addr <= chart_addr + AW'(1);
                                if (last_entry) begin
                                    state <= StDrain;
                                end
                            end else if (!chart_valid) begin
                                state <= StDrain;
                            end
                        end else if ((reserved == '0) && (pending == '0)) begin
                            state <= StEnd;
                        end
                    end
                end
                StEnd: begin
                    if (key_exit) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: a rule-level model checks the 4-slot instance every cycle;
// directed scenarios add literal expectations. A 2-slot/512-entry instance covers saturation.
module tb_note_scheduler;
    localparam int NS = 4;
    localparam int CD = 32;
    localparam int M_IDLE = 0, M_PLAY = 1, M_DRAIN = 2, M_END = 3;
`ifdef NOTE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  keycode = 8'h00, keycode_second = 8'h00, key2 = 8'h00;
    logic [4:0]  chart_addr;
    logic        chart_valid;
    logic [11:0] chart_tick;
    logic [1:0]  chart_lane, slot_lane;
    logic [3:0]  slot_spawn;
    logic        slot_clear, playing, finished;
    logic [3:0]  slot_done = 4'd0, slot_hit = 4'd0;
    logic [11:0] song_tick;
    logic [15:0] score;
    logic [7:0]  combo, miss_count;

    logic [8:0]  chart_addr2;
    logic [1:0]  slot_spawn2, done2 = 2'd0, hit2 = 2'd0, slot_lane2;
    logic        slot_clear2, playing2, finished2, chart_valid2;
    logic [11:0] song_tick2;
    logic [15:0] score2;
    logic [7:0]  combo2, miss2;

    bit rom_valid [CD];
    int rom_tick  [CD];
    int rom_lane  [CD];

    int total = 0;
    int bad = 0;

    assign chart_valid  = rom_valid[chart_addr];
    assign chart_tick   = 12'(rom_tick[chart_addr]);
    assign chart_lane   = 2'(rom_lane[chart_addr]);
    assign chart_valid2 = (chart_addr2 < 9'd300);

    always #5 frame_clk = ~frame_clk;

    note_scheduler u_dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode_second(keycode_second),
        .chart_addr(chart_addr), .chart_valid(chart_valid), .chart_tick(chart_tick),
        .chart_lane(chart_lane), .slot_spawn(slot_spawn), .slot_lane(slot_lane),
        .slot_clear(slot_clear), .slot_done(slot_done), .slot_hit(slot_hit),
        .song_tick(song_tick), .score(score), .combo(combo), .miss_count(miss_count),
        .playing(playing), .finished(finished)
    );

    note_scheduler #(.NUM_SLOTS(2), .CHART_DEPTH(512)) u_dut2 (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(key2), .keycode_second(8'h00),
        .chart_addr(chart_addr2), .chart_valid(chart_valid2), .chart_tick(12'd0),
        .chart_lane(chart_addr2[1:0]), .slot_spawn(slot_spawn2), .slot_lane(slot_lane2),
        .slot_clear(slot_clear2), .slot_done(done2), .slot_hit(hit2),
        .song_tick(song_tick2), .score(score2), .combo(combo2), .miss_count(miss2),
        .playing(playing2), .finished(finished2)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit key(input logic [7:0] k);
        return (keycode == k) || (keycode_second == k);
    endfunction

    // Model state: game mode, song time, chart index, score figures, slot bookkeeping
    int       m_st, m_tick, m_addr, m_score, m_combo, m_miss, m_stall;
    bit [3:0] m_res, m_pend, m_hitl;

    always @(negedge frame_clk) begin
        int sp, sv, exp_spawn, exp_lane;
        bit act, abort, due, stalled, skip, empty;
        if (Reset) begin
            m_st = M_IDLE; m_tick = 0; m_addr = 0; m_score = 0; m_combo = 0; m_miss = 0;
            m_stall = 0; m_res = '0; m_pend = '0; m_hitl = '0;
        end
        act   = (m_st == M_PLAY) || (m_st == M_DRAIN);
        abort = act && key(8'h29);
        due   = (m_st == M_PLAY) && !abort && rom_valid[m_addr] && (rom_tick[m_addr] <= m_tick);
        sp = -1;
        if (due) for (int i = 0; i < NS; i++) if (!m_res[i] && sp < 0) sp = i;
        stalled   = due && (sp < 0);
        exp_spawn = (sp >= 0) ? (1 << sp) : 0;
        exp_lane  = (sp >= 0) ? rom_lane[m_addr] : 0;

        check("addr", int'(chart_addr), m_addr);
        check("spawn", int'(slot_spawn), exp_spawn);
        check("lane", int'(slot_lane), exp_lane);
        check("clear", int'(slot_clear), int'(abort));
        check("tick", int'(song_tick), m_tick);
        check("score", int'(score), m_score);
        check("combo", int'(combo), m_combo);
        check("miss", int'(miss_count), m_miss);
        check("playing", int'(playing), int'(act));
        check("finished", int'(finished), int'(m_st == M_END));

        if (!Reset) begin
            case (m_st)
                M_IDLE: if (key(8'h2C)) begin
                    m_st = M_PLAY; m_tick = 0; m_addr = 0; m_score = 0; m_combo = 0;
                    m_miss = 0; m_stall = 0; m_res = '0; m_pend = '0; m_hitl = '0;
                end
                M_PLAY, M_DRAIN: if (abort) begin
                    m_st = M_IDLE; m_res = '0; m_pend = '0;
                end else begin
                    empty = (m_res == 0) && (m_pend == 0);
                    skip  = SKIP && stalled && (m_stall == 7);
                    sv = -1;
                    for (int i = 0; i < NS; i++) if (m_pend[i] && sv < 0) sv = i;
                    if (sv >= 0) begin
                        if (m_hitl[sv]) begin
                            m_score = min_i(m_score + 10, 65535);
                            m_combo = min_i(m_combo + 1, 255);
                        end else begin
                            m_combo = 0;
                            m_miss = min_i(m_miss + 1, 255);
                        end
                    end
                    if (skip) begin
                        m_combo = 0;
                        m_miss = min_i(m_miss + 1, 255);
                    end
                    for (int i = 0; i < NS; i++) begin
                        if (slot_done[i] && m_res[i]) begin
                            m_pend[i] = 1'b1;
                            m_hitl[i] = slot_hit[i];
                        end
                    end
                    if (sp >= 0) m_res[sp] = 1'b1;
                    if (sv >= 0) begin
                        m_res[sv] = 1'b0;
                        m_pend[sv] = 1'b0;
                    end
                    m_tick = min_i(m_tick + 1, 4095);
                    if (m_st == M_PLAY) begin
                        if (sp >= 0 || skip) begin
                            if (m_addr == CD - 1) m_st = M_DRAIN;
                            m_addr = (m_addr + 1) % CD;
                            m_stall = 0;
                        end else begin
                            if (stalled) m_stall++;
                            if (!rom_valid[m_addr]) m_st = M_DRAIN;
                        end
                    end else if (empty) begin
                        m_st = M_END;
                    end
                end
                M_END: if (key(8'h01)) m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
        end
    end

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        step();
        keycode = 8'h00;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < CD; i++) begin
            rom_valid[i] = 1'b0; rom_tick[i] = 0; rom_lane[i] = 0;
        end
    endtask

    initial begin
        int n;
        clear_rom();
        step();
        step();
        check("rst_addr", int'(chart_addr), 0);
        check("rst_play", int'(playing), 0);
        check("rst_score", int'(score), 0);
        Reset = 1'b0;

        // Two notes at tick 5, lanes 0 and 2
        rom_valid[0] = 1'b1; rom_tick[0] = 5; rom_lane[0] = 0;
        rom_valid[1] = 1'b1; rom_tick[1] = 5; rom_lane[1] = 2;
        press(8'h2C);
        n = 0;
        while (slot_spawn == 4'd0 && n < 20) begin
            step();
            n++;
        end
        check("a_wait", int'(n < 20), 1);
        check("a_tick0", int'(song_tick), 5);
        check("a_spawn0", int'(slot_spawn), 1);
        step();
        check("a_tick1", int'(song_tick), 6);
        check("a_spawn1", int'(slot_spawn), 2);
        check("a_lane1", int'(slot_lane), 2);
        step();
        step();
        step();
        check("a_addr", int'(chart_addr), 2);
        check("a_drain", int'(playing), 1);
        slot_done = 4'b0011;
        slot_hit  = 4'b0001;
        step();
        slot_done = 4'd0;
        slot_hit  = 4'd0;
        step();
        check("a_score", int'(score), 10);
        check("a_combo1", int'(combo), 1);
        step();
        check("a_combo0", int'(combo), 0);
        check("a_miss", int'(miss_count), 1);
        step();
        check("a_end", int'(finished), 1);
        press(8'h01);
        check("a_idle", int'(finished), 0);
        check("a_keep", int'(score), 10);

        // Five notes at tick 0, slots never complete: stall once all four are busy
        clear_rom();
        for (int i = 0; i < 5; i++) begin
            rom_valid[i] = 1'b1; rom_lane[i] = i % 4;
        end
        press(8'h2C);
        check("b_sp0", int'(slot_spawn), 1);
        step();
        check("b_sp1", int'(slot_spawn), 2);
        step();
        step();
        check("b_sp3", int'(slot_spawn), 8);
        check("b_lane3", int'(slot_lane), 3);
        step();
        check("b_stall", int'(slot_spawn), 0);
        repeat (8) step();
        check("b_tick", int'(song_tick), 12);
        check("b_addr", int'(chart_addr), SKIP ? 5 : 4);
        check("b_miss", int'(miss_count), SKIP ? 1 : 0);
        keycode = 8'h29;
        #1;
        check("b_clr", int'(slot_clear), 1);
        step();
        keycode = 8'h00;
        check("b_abort", int'(playing), 0);

        // Abort on the same cycle as an eligible spawn
        clear_rom();
        rom_valid[0] = 1'b1; rom_tick[0] = 0;  rom_lane[0] = 1;
        rom_valid[1] = 1'b1; rom_tick[1] = 10; rom_lane[1] = 3;
        press(8'h2C);
        step();
        slot_done = 4'b0001;
        slot_hit  = 4'b0001;
        step();
        slot_done = 4'd0;
        slot_hit  = 4'd0;
        step();
        check("c_score", int'(score), 10);
        n = 0;
        while (song_tick != 12'd10 && n < 30) begin
            step();
            n++;
        end
        check("c_wait", int'(n < 30), 1);
        check("c_elig", int'(slot_spawn), 1);
        keycode = 8'h29;
        #1;
        check("c_nospawn", int'(slot_spawn), 0);
        check("c_clr", int'(slot_clear), 1);
        step();
        keycode = 8'h00;
        check("c_idle", int'(playing), 0);
        check("c_keep", int'(score), 10);

        // Asynchronous reset in mid-song with two slots busy
        clear_rom();
        rom_valid[0] = 1'b1;
        rom_valid[1] = 1'b1;
        rom_valid[2] = 1'b1; rom_tick[2] = 100;
        press(8'h2C);
        step();
        step();
        Reset = 1'b1;
        #1;
        check("d_play", int'(playing), 0);
        check("d_addr", int'(chart_addr), 0);
        check("d_tick", int'(song_tick), 0);
        check("d_spawn", int'(slot_spawn), 0);
        step();
        Reset = 1'b0;
        press(8'h2C);
        check("d_addr2", int'(chart_addr), 0);
        check("d_sp0", int'(slot_spawn), 1);

        // 300 straight hits on the 2-slot instance
        key2 = 8'h2C;
        step();
        key2 = 8'h00;
        check("e_sp0", int'(slot_spawn2), 1);
        done2 = 2'b11;
        hit2  = 2'b11;
        step();
        check("e_sp1", int'(slot_spawn2), 2);
        n = 0;
        while (!finished2 && n < 3000) begin
            step();
            n++;
        end
        check("e_end", int'(finished2), 1);
        check("e_score", int'(score2), 3000);
        check("e_combo", int'(combo2), 255);
        check("e_miss", int'(miss2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
